mdu: RTL
========

# mdu

Multiply/divide unit of the P7 pipelined MIPS core, in the E stage directly downstream of the GRF read ports. It consumes the two forwarded GRF operands, runs mult/multu/div/divu over a fixed multi-cycle latency, and holds the results in the architectural HI/LO registers. mthi/mtlo write HI/LO directly; mfhi/mflo read them back toward the W-stage GRF write path. It drives `busy` so the hazard unit can stall later md-class instructions in D.

## Interface
- `MULT_CYCLES`, 5, busy cycles for mult/multu (≥1)
- `DIV_CYCLES`, 10, busy cycles for div/divu (≥1)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `op`  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- `req`  in  1  exception/interrupt flush of the E-stage instruction; suppresses `op` this cycle
- `A`  in  32  rs operand, forwarded GRF RD1
- `B`  in  32  rt operand, forwarded GRF RD2
- `rd_sel`  in  1  0 selects HI, 1 selects LO on `out`
- `busy`  out  1  registered; high while an operation is in flight
- `HI`  out  32  architectural HI register
- `LO`  out  32  architectural LO register
- `out`  out  32  combinational: `rd_sel ? LO : HI`

## Operation
- One clock, `clk`. `reset` is asynchronous and active-low.
- States: IDLE, RUN. A counter of width ⌈log2(max(MULT_CYCLES, DIV_CYCLES)+1)⌉ tracks the remaining busy cycles.
- Accept condition: state IDLE, `req`=0, and `op` in 1..6. When `op` is not accepted, it has no effect.
- mult/multu/div/divu accepted at an edge:
  - Compute the 64-bit result from `A` and `B` captured at that edge, and hold it in pending registers.
  - Load the counter with N, where N = MULT_CYCLES or DIV_CYCLES.
  - Go to RUN, with `busy` high.
- RUN: the counter decrements every edge. At the edge where it reaches 0:
  - Write the pending result to HI/LO.
  - Return to IDLE, with `busy` low.
- mult: {HI,LO} = signed A × signed B. multu: {HI,LO} = unsigned product.
- div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- divu: unsigned quotient to LO, unsigned remainder to HI.
- B = 0 on div/divu: HI and LO stay unchanged. The unit still goes busy for the full DIV_CYCLES.
- div 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. This must not trap and must not produce X.
- mthi/mtlo accepted: HI (or LO) ← `A` at that edge. No busy cycle.
- `op` arriving while `busy`: ignored, HI/LO untouched. The hazard unit is responsible for stalling; the unit does not queue.
- `req` does not cancel an operation already in RUN. Only the current-cycle `op` is suppressed.
- Reset low, at any time including mid-RUN:
  - Outputs immediately become `busy`=0, HI=LO=0, state IDLE, counter 0.
  - The pending result is discarded.

## Timing
- Reset values: `busy`=0, HI=0, LO=0. `out` = 0 follows from these.
- Multiply or divide accepted at edge E0:
  - `busy` is high for exactly N cycles, following edges E0 through E(N-1).
  - HI/LO update and `busy` falls at edge EN.
  - New values are visible in the cycle after EN, together with `busy`=0.
- A new op can be accepted at EN+1, not at EN.
- mthi/mtlo accepted at E0: the new value is visible after E0.
- Back-to-back mthi then mflo: both execute with no stall.
- `out` reflects HI/LO combinationally, so there is no read latency. A write at an edge becomes visible on `out` in the following cycle. There is no same-cycle bypass.
- Hazard unit stall term: D-stage md-class instruction AND (`busy` OR E-stage `op` in 1..4).

## Test plan
- **mult signed and unsigned.** Reset, then mult A=0xFFFFFFFF B=0x00000002. Required: `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Then multu with the same operands. Required: HI=0x00000001, LO=0xFFFFFFFE.
- **div signed and unsigned.** div A=0xFFFFFFF9 (−7) B=2. Required: `busy` 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu A=7 B=2. Required: LO=3, HI=1.
- **Divide corner cases.** Preload HI=0x11, LO=0x22 via mthi/mtlo, then div A=5 B=0. Required: 10 busy cycles, HI=0x11, LO=0x22 unchanged. Then div A=0x80000000 B=0xFFFFFFFF. Required: LO=0x80000000, HI=0.
- **Ops ignored while busy.** Start mult A=3 B=4. Apply mtlo A=0xDEAD and divu on busy cycles 2 and 3. Required: final HI=0, LO=0xC, and `busy` falls after exactly 5 cycles.
- **Idle mthi and flush.** With the unit idle, mthi A=0x1234 and `rd_sel`=0. Required: `out`=0x1234 on the next cycle, `busy` never rises. Then assert mult A=2 B=2 together with `req`=1. Required: `busy` stays 0, LO unchanged.
- **Reset mid-operation.** Drive `reset` low asynchronously during busy cycle 4 of a div. Required: `busy`=0, HI=LO=0 without waiting for a clock edge. After release, mult A=6 B=7. Required: LO=42 after 5 cycles.

Source files
------------

// File: rtl/mdu.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mdu
// Description : Multiply/divide unit for the E stage of the pipelined core.
//               Runs mult/multu/div/divu over a fixed multi-cycle latency,
//               holds the architectural HI/LO registers, and services
//               mthi/mtlo writes and mfhi/mflo reads.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  op,
    input  logic        req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [63:0]      pend_q, pend_d;
    logic             pend_wr_q, pend_wr_d;

    // Products: zero/sign-extended 64x64 multiply, low 64 bits are exact
    logic [63:0] w_umul;
    logic [63:0] w_smul;

    // Division works on magnitudes so the most-negative / -1 case cannot overflow
    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_divisor;
    logic [31:0] w_quo_mag;
    logic [31:0] w_rem_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_umul = {32'd0, A} * {32'd0, B};
    assign w_smul = {{32{A[31]}}, A} * {{32{B[31]}}, B};

    assign w_div_signed = (op == OP_DIV);
    assign w_a_neg      = w_div_signed & A[31];
    assign w_b_neg      = w_div_signed & B[31];
    assign w_mag_a      = w_a_neg ? (~A + 32'd1) : A;
    assign w_mag_b      = w_b_neg ? (~B + 32'd1) : B;
    // A zero divisor never reaches HI/LO; substitute 1 to keep the divider X-free
    assign w_divisor    = (B == 32'd0) ? 32'd1 : w_mag_b;
    assign w_quo_mag    = w_mag_a / w_divisor;
    assign w_rem_mag    = w_mag_a % w_divisor;
    assign w_quo        = (w_a_neg ^ w_b_neg) ? (~w_quo_mag + 32'd1) : w_quo_mag;
    assign w_rem        = w_a_neg ? (~w_rem_mag + 32'd1) : w_rem_mag;

    // Next-state: accept new ops only when idle and not flushed; retire on last count
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (!req) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            pend_d    = (op == OP_MULT) ? w_smul : w_umul;
                            pend_wr_d = 1'b1;
                            cnt_d     = MULT_N;
                            state_d   = ST_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_d    = {w_rem, w_quo};
                            pend_wr_d = (B != 32'd0);
                            cnt_d     = DIV_N;
                            state_d   = ST_RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            default: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                    pend_wr_d = 1'b0;
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_q    <= 64'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;
    assign out  = rd_sel ? lo_q : hi_q;

endmodule
`default_nettype wire
